// File: rtl/regfile_scb_pkg.sv
// Shared types, derived constants and the byte-merge helper for the register file.
package regfile_scb_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DEPTH  = 2 ** RF_ADDR_W;
    localparam int unsigned RF_NBYTES = RF_DATA_W / 8;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int unsigned RF_MAX_W  = 256;
    localparam int unsigned RF_MAX_NB = RF_MAX_W / 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

    // Take new bytes where the strobe is set, keep old bytes elsewhere.
    function automatic logic [RF_MAX_W-1:0] rf_byte_merge(
        input logic [RF_MAX_W-1:0]  old_w,
        input logic [RF_MAX_W-1:0]  new_w,
        input logic [RF_MAX_NB-1:0] strb
    );
        logic [RF_MAX_W-1:0] res;
        res = old_w;
        for (int k = 0; k < int'(RF_MAX_NB); k++) begin
            if (strb[k]) begin
                res[k*8 +: 8] = new_w[k*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_scb_rf_scoreboard.sv
// Busy bit per register: set at decode issue, cleared by the producer's last write.
module rf_scoreboard
    import regfile_scb_pkg::*;
#(
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en_i,
    input  logic                     set_i,
    input  logic [ADDR_W-1:0]        set_addr_i,
    input  logic                     flush_i,
    input  logic                     clr_i,
    input  logic [ADDR_W-1:0]        clr_addr_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]        ready_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam bit          ZR    = (ZERO_REG != 0);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Flush beats set, set beats a same-address clear.
    always_comb begin
        busy_d = busy_q;
        if (en_i) begin
            if (flush_i) begin
                busy_d = '0;
            end else begin
                if (clr_i) begin
                    busy_d[clr_addr_i] = 1'b0;
                end
                if (set_i && !(ZR && (set_addr_i == '0))) begin
                    busy_d[set_addr_i] = 1'b1;
                end
            end
        end
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Operand is ready when not pending or being written back this cycle.
    always_comb begin
        logic [ADDR_W-1:0] a;
        ready_c = '0;
        a       = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            a          = rd_addr_i[i*ADDR_W +: ADDR_W];
            ready_c[i] = (ZR && (a == '0)) || !busy_q[a] || (clr_i && (clr_addr_i == a));
        end
    end

endmodule

// File: rtl/regfile_scb.sv
// Multi-port register file with byte-strobed writes, bypass, init sweep and scoreboard.
module regfile_scb
    import regfile_scb_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_ready,
    input  logic                     wen,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W/8-1:0]      wstrb,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     wlast,
    input  logic                     set_busy,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     flush,
    output logic                     init_done,
    output logic [DATA_W/8-1:0]      debug_wb_rf_wen,
    output logic [ADDR_W-1:0]        debug_wb_rf_wnum,
    output logic [DATA_W-1:0]        debug_wb_rf_wdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam bit          ZR    = (ZERO_REG != 0);

    rf_state_e         state_q;
    rf_state_e         state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              run_c;
    logic              wr_eff_c;
    logic [DATA_W-1:0] merged_c;
    logic [NUM_RD-1:0] sb_ready_c;

    // Init-sweep FSM state and counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep every entry once, then run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    assign run_c     = (state_q == RUN);
    assign wr_eff_c  = run_c && wen && !(ZR && (waddr == '0));
    assign merged_c  = DATA_W'(rf_byte_merge(RF_MAX_W'(mem_q[waddr]),
                                             RF_MAX_W'(wdata),
                                             RF_MAX_NB'(wstrb)));
    assign init_done = run_c;

    // Storage: zero during the sweep, byte-merged writes afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == INIT) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_eff_c) begin
                mem_q[waddr] <= merged_c;
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .en_i       (run_c),
        .set_i      (set_busy),
        .set_addr_i (set_addr),
        .flush_i    (flush),
        .clr_i      (wen && wlast),
        .clr_addr_i (waddr),
        .rd_addr_i  (rd_addr),
        .ready_c    (sb_ready_c)
    );

    // Read ports: zero register, write bypass, then storage; silent during init.
    always_comb begin
        logic [ADDR_W-1:0] a;
        rd_data  = '0;
        rd_ready = '0;
        a        = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            a = rd_addr[i*ADDR_W +: ADDR_W];
            if (run_c) begin
                if (ZR && (a == '0)) begin
                    rd_data[i*DATA_W +: DATA_W] = '0;
                end else if (wr_eff_c && (a == waddr)) begin
                    rd_data[i*DATA_W +: DATA_W] = merged_c;
                end else begin
                    rd_data[i*DATA_W +: DATA_W] = mem_q[a];
                end
                rd_ready[i] = sb_ready_c[i];
            end
        end
    end

    // Write-back trace of what actually lands in storage this cycle.
    assign debug_wb_rf_wen   = wr_eff_c ? wstrb : '0;
    assign debug_wb_rf_wnum  = waddr;
    assign debug_wb_rf_wdata = wdata;

endmodule

// File: tb/tb_regfile_scb.sv
// Bench for regfile_scb: reference model, per-cycle compare and directed vectors.
module tb_regfile_scb;

    logic        clk;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_ready;
    logic        wen;
    logic [4:0]  waddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        wlast;
    logic        set_busy;
    logic [4:0]  set_addr;
    logic        flush;
    logic        init_done;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int checks   = 0;
    int failures = 0;

    regfile_scb dut (
        .clk               (clk),
        .reset             (reset),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .rd_ready          (rd_ready),
        .wen               (wen),
        .waddr             (waddr),
        .wstrb             (wstrb),
        .wdata             (wdata),
        .wlast             (wlast),
        .set_busy          (set_busy),
        .set_addr          (set_addr),
        .flush             (flush),
        .init_done         (init_done),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mdl_mem  [32];
    bit          mdl_busy [32];
    int          since_rst = 0;
    bit          armed     = 0;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        end
        return r;
    endfunction

    // Advance the model at each rising edge from the inputs held over the cycle.
    always @(posedge clk) begin
        if (reset) begin
            since_rst = 0;
            armed     = 1;
            for (int r = 0; r < 32; r++) begin
                mdl_mem[r]  = '0;
                mdl_busy[r] = 0;
            end
        end else if (armed && since_rst < 32) begin
            since_rst++;
        end else if (armed) begin
            if (wen && waddr != 0) mdl_mem[waddr] = bmerge(mdl_mem[waddr], wdata, wstrb);
            if (flush) begin
                for (int r = 0; r < 32; r++) mdl_busy[r] = 0;
            end else begin
                if (wen && wlast) mdl_busy[waddr] = 0;
                if (set_busy && set_addr != 0) mdl_busy[set_addr] = 1;
            end
        end
    end

    // Mid-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (armed) begin
            bit          done;
            logic [4:0]  a;
            logic [31:0] ed;
            bit          er;
            done = (since_rst >= 32);
            chk("init_done", 64'(init_done), 64'(done));
            for (int i = 0; i < 2; i++) begin
                a  = rd_addr[i*5 +: 5];
                ed = '0;
                er = 0;
                if (done) begin
                    if (a == 0)                          ed = '0;
                    else if (wen && waddr == a)          ed = bmerge(mdl_mem[a], wdata, wstrb);
                    else                                 ed = mdl_mem[a];
                    er = (a == 0) || !mdl_busy[a] || (wen && wlast && waddr == a);
                end
                chk($sformatf("rd_data%0d", i), 64'(rd_data[i*32 +: 32]), 64'(ed));
                chk($sformatf("rd_ready%0d", i), 64'(rd_ready[i]), 64'(er));
            end
            chk("dbg_wen", 64'(debug_wb_rf_wen),
                64'((done && wen && waddr != 0) ? wstrb : 4'b0000));
            chk("dbg_wnum", 64'(debug_wb_rf_wnum), 64'(waddr));
            chk("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(wdata));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rd_addr  = {5'd3, 5'd3};
        wen      = 1'b0;
        waddr    = '0;
        wstrb    = '0;
        wdata    = '0;
        wlast    = 1'b0;
        set_busy = 1'b0;
        set_addr = '0;
        flush    = 1'b0;

        // Reset and the 32-cycle sweep.
        cyc();
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            cyc();
            #2;
            chk($sformatf("sweep_done_k%0d", k), 64'(init_done), 64'(k == 32));
            if (k < 32) chk("sweep_ready", 64'(rd_ready), 64'h0);
            if (k == 32) chk("sweep_r3_zero", rd_data, 64'h0);
        end

        // Full write then partial-strobe write with same-cycle read.
        wen = 1'b1; waddr = 5'd5; wstrb = 4'b1111; wdata = 32'hAABBCCDD;
        cyc();
        wstrb = 4'b0010; wdata = 32'h00001100; rd_addr = {5'd3, 5'd5};
        #2;
        chk("bypass_merge", 64'(rd_data[31:0]), 64'h00000000AABB11DD);
        cyc();
        wen = 1'b0;
        #2;
        chk("stored_merge", 64'(rd_data[31:0]), 64'h00000000AABB11DD);

        // Writes and busy sets on r0 are ignored.
        cyc();
        wen = 1'b1; waddr = 5'd0; wstrb = 4'b1111; wdata = 32'hFFFFFFFF;
        set_busy = 1'b1; set_addr = 5'd0; rd_addr = {5'd0, 5'd0};
        #2;
        chk("r0_data", rd_data, 64'h0);
        chk("r0_ready", 64'(rd_ready), 64'h3);
        chk("r0_dbg_wen", 64'(debug_wb_rf_wen), 64'h0);
        cyc();
        wen = 1'b0; set_busy = 1'b0;
        #2;
        chk("r0_ready_after", 64'(rd_ready), 64'h3);

        // Busy r7 stays pending until the producer's last write.
        cyc();
        set_busy = 1'b1; set_addr = 5'd7; rd_addr = {5'd0, 5'd7};
        cyc();
        set_busy = 1'b0; wen = 1'b1; waddr = 5'd7; wlast = 1'b0; wstrb = 4'b1111; wdata = 32'h77;
        #2;
        chk("r7_not_last", 64'(rd_ready[0]), 64'h0);
        cyc();
        wlast = 1'b1;
        #2;
        chk("r7_last_ready", 64'(rd_ready[0]), 64'h1);
        chk("r7_last_data", 64'(rd_data[31:0]), 64'h77);
        cyc();
        wen = 1'b0; wlast = 1'b0;
        #2;
        chk("r7_after", 64'(rd_ready[0]), 64'h1);

        // Same-cycle clear and set on r9: set wins. Then flush drops a set on r4.
        cyc();
        wen = 1'b1; wlast = 1'b1; waddr = 5'd9; wdata = 32'h99;
        set_busy = 1'b1; set_addr = 5'd9; rd_addr = {5'd9, 5'd9};
        cyc();
        wen = 1'b0; wlast = 1'b0; set_busy = 1'b0;
        #2;
        chk("r9_still_busy", 64'(rd_ready), 64'h0);
        cyc();
        flush = 1'b1; set_busy = 1'b1; set_addr = 5'd4; rd_addr = {5'd4, 5'd9};
        cyc();
        flush = 1'b0; set_busy = 1'b0;
        #2;
        chk("flush_ready", 64'(rd_ready), 64'h3);

        // Reset mid-sweep restarts the sweep and clears r2.
        cyc();
        wen = 1'b1; waddr = 5'd2; wstrb = 4'b1111; wdata = 32'h1234; rd_addr = {5'd3, 5'd2};
        cyc();
        wen = 1'b0;
        #2;
        chk("r2_written", 64'(rd_data[31:0]), 64'h1234);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk("partial_sweep", 64'(init_done), 64'h0);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            cyc();
            #2;
            chk($sformatf("resweep_done_k%0d", k), 64'(init_done), 64'(k == 32));
            if (k == 32) chk("r2_cleared", 64'(rd_data[31:0]), 64'h0);
        end

        cyc();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_scb.md
Name: regfile_scb

Overview:
- Parametrised successor to the CPU's three-port register file.
- Keeps the existing features: byte-strobed writes, write-to-read bypass, hardwired r0 and the debug write-back trace.
- Adds NUM_RD combinational read ports, per-register busy scoreboard bits, and a post-reset sequential init sweep that zeroes storage.
- Sits between decode (reads, scoreboard set) and write-back (writes, scoreboard clear).

Parameters:
- DATA_W, 32, register width; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and busy sets.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, combinational.
- rd_ready  out  NUM_RD  operand valid (not pending), combinational.
- wen  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wstrb  in  DATA_W/8  byte strobes.
- wdata  in  DATA_W  write data.
- wlast  in  1  final write of this producer; clears busy[waddr].
- set_busy  in  1  mark set_addr pending (decode issue).
- set_addr  in  ADDR_W  register to mark.
- flush  in  1  clear all busy bits.
- init_done  out  1  storage sweep complete.
- debug_wb_rf_wen  out  DATA_W/8  effective byte strobes written this cycle.
- debug_wb_rf_wnum  out  ADDR_W  waddr.
- debug_wb_rf_wdata  out  DATA_W  wdata.

Behaviour:
- Reset:
  - FSM enters INIT; sweep counter = 0; all busy bits = 0.
  - init_done = 0, rd_ready = 0, rd_data = 0, debug_wb_rf_wen = 0.
- FSM states: INIT and RUN.
  - INIT writes 0 to entry[counter] once per cycle, for DEPTH cycles, then moves to RUN.
  - init_done rises on the first RUN cycle, i.e. DEPTH cycles after reset deasserts.
  - reset asserted in any state (including mid-sweep) restarts INIT from counter 0.
- During INIT:
  - wen, set_busy and flush are ignored.
  - rd_data = 0 and rd_ready = 0.
  - debug_wb_rf_wen = 0.
- Write (RUN):
  - Effective write = wen && !(ZERO_REG && waddr == 0).
  - Byte k of entry[waddr] takes wdata byte k when wstrb[k] = 1; other bytes are unchanged.
  - debug_wb_rf_wen = wstrb gated by the effective write.
- Read port i:
  - Register 0 with ZERO_REG set: returns 0.
  - Address equal to waddr with an effective write: returns the byte-merge (wdata where wstrb = 1, stored byte elsewhere). Partial strobes never forward stale full words.
  - Otherwise returns entry[rd_addr_i].
  - All ports are independent; identical addresses on several ports are legal.
- Scoreboard (RUN), priority per cycle:
  1. flush clears every busy bit; any same-cycle set_busy is dropped.
  2. set_busy sets busy[set_addr]. set_addr = 0 is ignored when ZERO_REG = 1.
  3. wen && wlast clears busy[waddr], unless the same address is set in the same cycle (set wins: new producer).
  - wen without wlast never changes busy.
- rd_ready[i]:
  - = init_done && (zero-reg address || !busy[a] || (wen && wlast && waddr == a)).
  - The write-back in the same cycle satisfies the reader through the bypass.
- Width rule: rd_data and wdata are always DATA_W; no sign or zero extension is done inside the block.

Decomposition:
- Shared package holds:
  - rf_state_e {INIT, RUN};
  - the byte-merge function (old, new, strobe) -> merged word;
  - constants RF_DEPTH and RF_NBYTES, derived from the parameters.
- One natural sub-module: rf_scoreboard, which holds the busy bit-vector, the set/clear/flush priority and the ready-term generation.
- Storage, bypass and the init FSM stay in the top module.

Test Plan:
- Reset then idle with all rd_addr = 3 → rd_ready = 0 for 32 cycles; init_done = 1 on cycle 32; rd_data = 0.
- Write r5 = 0xAABBCCDD (wstrb = 1111), next cycle wstrb = 0010 with wdata = 0x00001100, rd_addr0 = 5 in that same cycle → rd_data0 = 0xAABB11DD (bypassed merge); the following cycle it reads 0xAABB11DD from storage.
- Write r0 = 0xFFFFFFFF, set_busy with set_addr = 0 → rd_data = 0, rd_ready = 1, debug_wb_rf_wen = 0000.
- set_busy r7; a cycle with wen, wlast = 0 → rd_ready = 0; next cycle wen, wlast = 1, waddr = 7 → rd_ready = 1 in that same cycle and thereafter.
- Same cycle: wen + wlast on r9 and set_busy on r9 → busy[9] stays 1. Then flush together with set_busy on r4 → both r4 and r9 are ready.
- Assert reset at sweep count 10 after a prior RUN with r2 = 0x1234 → sweep restarts; 32 cycles later init_done = 1 and r2 reads 0.
